axi_fifo_arb: RTL

AXI_FIFO_ARB -- requirements
Module: axi_fifo_arb

---
 rtl/axi_fifo_arb.sv | 114 +++++++++++
 1 files changed

// File: rtl/axi_fifo_arb.sv
// Round-robin arbiter granting whole write bursts from NREQ requesters into one shared FIFO.
// Optional ARB_BURST_LIMIT_EN macro truncates any burst after MAXB accepted beats.
module axi_fifo_arb #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned DWID = 32,
    parameter int unsigned MAXB = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      last,
    input  logic [NREQ*DWID-1:0] din,
    output logic [NREQ-1:0]      ack,
    output logic [NREQ-1:0]      gnt,
    output logic                 busy,
    input  logic                 fifo_full,
    output logic                 fifo_wren,
    output logic [DWID-1:0]      fifo_data
);

    localparam int unsigned PW = $clog2(NREQ);
    localparam int unsigned CW = $clog2(MAXB) + 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   ptr, ptr_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic            busy_nxt;
    logic            found_c;
    logic [PW-1:0]   win_c;
    logic            beat_c;
    logic            burst_end_c;

    // Round-robin search starting just after the last winner.
    always_comb begin
        int unsigned idx;
        found_c = 1'b0;
        win_c   = ptr;
        idx     = 0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = (32'(ptr) + k) % NREQ;
            if (!found_c && req[PW'(idx)]) begin
                found_c = 1'b1;
                win_c   = PW'(idx);
            end
        end
    end

    // ptr holds the owner while in BURST; reset kills acceptance in the same cycle.
    always_comb begin
        beat_c    = (state == BURST) && !rst && req[ptr] && !fifo_full;
        ack       = beat_c ? (NREQ'(1) << ptr) : '0;
        fifo_wren = beat_c;
        fifo_data = (state == BURST) ? din[32'(ptr)*DWID +: DWID] : '0;
`ifdef ARB_BURST_LIMIT_EN
        burst_end_c = beat_c && (last[ptr] || ((cnt + CW'(1)) == CW'(MAXB)));
`else
        burst_end_c = beat_c && last[ptr];
`endif
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        gnt_nxt   = gnt;
        busy_nxt  = busy;
        case (state)
            IDLE: begin
                if (found_c) begin
                    state_nxt = BURST;
                    ptr_nxt   = win_c;
                    cnt_nxt   = '0;
                    gnt_nxt   = NREQ'(1) << win_c;
                    busy_nxt  = 1'b1;
                end
            end
            BURST: begin
                if (beat_c) begin
                    cnt_nxt = cnt + CW'(1);
                end
                if (burst_end_c) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= PW'(NREQ - 1);
            cnt   <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            gnt   <= gnt_nxt;
            busy  <= busy_nxt;
        end
    end

endmodule
